// File: rtl/ball_game_ctrl.sv
// Frame-synchronous game sequencer: IDLE/SERVE/PLAY/PAUSE flow, per-frame update strobe,
// bounce counting and speed levels. Define LEVEL_SPEEDUP_EN to enable level accounting and step boost.
module ball_game_ctrl #(
  parameter int unsigned SERVE_FRAMES      = 60,
  parameter int unsigned BOUNCES_PER_LEVEL = 8,
  parameter int unsigned MAX_LEVEL         = 7
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       vs_in,
  input  logic       start_in,
  input  logic       pause_in,
  input  logic [3:0] hit_in,
  input  logic [3:0] x_step_sw,
  input  logic [3:0] y_step_sw,
  output logic       upd_stb,
  output logic [3:0] x_step_out,
  output logic [3:0] y_step_out,
  output logic [2:0] level,
  output logic [7:0] bounce_cnt,
  output logic [1:0] state_out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SERVE = 2'b01,
    ST_PLAY  = 2'b10,
    ST_PAUSE = 2'b11
  } state_t;

  localparam logic [7:0] SERVE_LOAD = 8'(SERVE_FRAMES - 1);

  if (SERVE_FRAMES < 1 || SERVE_FRAMES > 255) begin : g_bad_serve
    $error("SERVE_FRAMES out of range 1..255");
  end
  if (BOUNCES_PER_LEVEL < 4 || BOUNCES_PER_LEVEL > 63) begin : g_bad_bpl
    $error("BOUNCES_PER_LEVEL out of range 4..63");
  end
  if (MAX_LEVEL > 7) begin : g_bad_max
    $error("MAX_LEVEL out of range 0..7");
  end

  state_t     state;
  logic       vs_d;
  logic       start_d;
  logic [7:0] serve_cnt;
  logic [3:0] base_x;
  logic [3:0] base_y;

  logic       tick;
  logic       start_edge;
  logic [2:0] pc;
  logic [8:0] bounce_sum;
  logic [7:0] bounce_next;

  assign state_out = state;

  always_comb begin
    tick        = vs_d & ~vs_in;
    start_edge  = start_in & ~start_d;
    pc          = 3'(hit_in[0]) + 3'(hit_in[1]) + 3'(hit_in[2]) + 3'(hit_in[3]);
    bounce_sum  = {1'b0, bounce_cnt} + 9'(pc);
    bounce_next = bounce_sum[8] ? 8'hFF : bounce_sum[7:0];
  end

`ifdef LEVEL_SPEEDUP_EN
  localparam logic [6:0] BPL     = 7'(BOUNCES_PER_LEVEL);
  localparam logic [2:0] LVL_MAX = 3'(MAX_LEVEL);

  logic [5:0] lvl_cnt;
  logic [6:0] lvl_sum;
  logic       lvl_wrap;
  logic [4:0] x_sum;
  logic [4:0] y_sum;
  logic [3:0] x_eff;
  logic [3:0] y_eff;

  always_comb begin
    lvl_sum  = {1'b0, lvl_cnt} + 7'(pc);
    lvl_wrap = (lvl_sum >= BPL);
    x_sum    = {1'b0, base_x} + {2'b00, level};
    y_sum    = {1'b0, base_y} + {2'b00, level};
    x_eff    = x_sum[4] ? 4'hF : x_sum[3:0];
    y_eff    = y_sum[4] ? 4'hF : y_sum[3:0];
  end
`else
  logic [3:0] x_eff;
  logic [3:0] y_eff;

  assign level = '0;

  always_comb begin
    x_eff = base_x;
    y_eff = base_y;
  end
`endif

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state      <= ST_IDLE;
      vs_d       <= 1'b1;
      start_d    <= 1'b0;
      upd_stb    <= 1'b0;
      serve_cnt  <= '0;
      base_x     <= 4'd1;
      base_y     <= 4'd1;
      x_step_out <= 4'd1;
      y_step_out <= 4'd1;
      bounce_cnt <= '0;
`ifdef LEVEL_SPEEDUP_EN
      level      <= '0;
      lvl_cnt    <= '0;
`endif
    end else begin
      vs_d       <= vs_in;
      start_d    <= start_in;
      upd_stb    <= 1'b0;
      // Steps follow the registered level, so they trail a level change by one cycle.
      x_step_out <= x_eff;
      y_step_out <= y_eff;

      if (start_edge) begin
        // A restart wins over a same-cycle frame tick; no strobe is issued.
        state      <= ST_SERVE;
        base_x     <= (x_step_sw == 4'd0) ? 4'd1 : x_step_sw;
        base_y     <= (y_step_sw == 4'd0) ? 4'd1 : y_step_sw;
        bounce_cnt <= '0;
        serve_cnt  <= SERVE_LOAD;
`ifdef LEVEL_SPEEDUP_EN
        level      <= '0;
        lvl_cnt    <= '0;
`endif
      end else if (tick) begin
        unique case (state)
          ST_SERVE: begin
            if (!pause_in) begin
              if (serve_cnt == 8'd0) state <= ST_PLAY;
              else serve_cnt <= serve_cnt - 8'd1;
            end
          end
          ST_PLAY: begin
            if (pause_in) begin
              state <= ST_PAUSE;
            end else begin
              upd_stb    <= 1'b1;
              bounce_cnt <= bounce_next;
`ifdef LEVEL_SPEEDUP_EN
              // At most one level per frame; the remainder carries into the next level.
              if (lvl_wrap) begin
                lvl_cnt <= 6'(lvl_sum - BPL);
                if (level < LVL_MAX) level <= level + 3'd1;
              end else begin
                lvl_cnt <= lvl_sum[5:0];
              end
`endif
            end
          end
          ST_PAUSE: begin
            if (!pause_in) state <= ST_PLAY;
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ball_game_ctrl.sv
// Directed, table-driven bench for ball_game_ctrl (SERVE_FRAMES=3, BOUNCES_PER_LEVEL=8, MAX_LEVEL=7).
module tb_ball_game_ctrl;

  logic       clk_in = 1'b0;
  logic       rst;
  logic       vs_in;
  logic       start_in;
  logic       pause_in;
  logic [3:0] hit_in;
  logic [3:0] x_step_sw;
  logic [3:0] y_step_sw;
  logic       upd_stb;
  logic [3:0] x_step_out;
  logic [3:0] y_step_out;
  logic [2:0] level;
  logic [7:0] bounce_cnt;
  logic [1:0] state_out;

  int n_checks = 0;
  int n_fail   = 0;

  ball_game_ctrl #(
    .SERVE_FRAMES(3),
    .BOUNCES_PER_LEVEL(8),
    .MAX_LEVEL(7)
  ) dut (
    .clk_in(clk_in),
    .rst(rst),
    .vs_in(vs_in),
    .start_in(start_in),
    .pause_in(pause_in),
    .hit_in(hit_in),
    .x_step_sw(x_step_sw),
    .y_step_sw(y_step_sw),
    .upd_stb(upd_stb),
    .x_step_out(x_step_out),
    .y_step_out(y_step_out),
    .level(level),
    .bounce_cnt(bounce_cnt),
    .state_out(state_out)
  );

  always #20 clk_in = ~clk_in;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

`ifdef LEVEL_SPEEDUP_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif

  typedef struct {
    logic       pause;
    logic [3:0] hit;
    logic       stb;
    logic [1:0] st;
    int         bounce;
    int         lvl_on;
    int         x_on;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  // One frame: falling vs_in edge, strobe sampled right after the tick edge,
  // then junk on hit/pause for a few cycles which the DUT must ignore.
  task automatic do_tick(input logic p, input logic [3:0] h, output logic stb);
    pause_in = p;
    hit_in   = h;
    vs_in    = 1'b0;
    cyc();
    stb      = upd_stb;
    vs_in    = 1'b1;
    pause_in = ~p;
    hit_in   = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("stb_quiet", 32'(upd_stb), 32'd0);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 32'(state_out), 32'd0);
    chk({tag, "_stb"}, 32'(upd_stb), 32'd0);
    chk({tag, "_level"}, 32'(level), 32'd0);
    chk({tag, "_bounce"}, 32'(bounce_cnt), 32'd0);
    chk({tag, "_x"}, 32'(x_step_out), 32'd1);
    chk({tag, "_y"}, 32'(y_step_out), 32'd1);
  endtask

  task automatic pulse_start();
    start_in = 1'b1;
    cyc();
    start_in = 1'b0;
    cyc();
    cyc();
  endtask

  initial begin
    logic stb;
    int   exp_b;
    int   exp_l;
    int   exp_x;

    vecs[0]  = '{1'b0, 4'b0000, 1'b0, 2'b01, 0, 0, 2};
    vecs[1]  = '{1'b1, 4'b0000, 1'b0, 2'b01, 0, 0, 2};
    vecs[2]  = '{1'b0, 4'b0000, 1'b0, 2'b01, 0, 0, 2};
    vecs[3]  = '{1'b0, 4'b0000, 1'b0, 2'b10, 0, 0, 2};
    vecs[4]  = '{1'b0, 4'b0101, 1'b1, 2'b10, 2, 0, 2};
    vecs[5]  = '{1'b0, 4'b0101, 1'b1, 2'b10, 4, 0, 2};
    vecs[6]  = '{1'b0, 4'b0101, 1'b1, 2'b10, 6, 0, 2};
    vecs[7]  = '{1'b0, 4'b0101, 1'b1, 2'b10, 8, 1, 3};
    vecs[8]  = '{1'b1, 4'b0101, 1'b0, 2'b11, 8, 1, 3};
    vecs[9]  = '{1'b1, 4'b1111, 1'b0, 2'b11, 8, 1, 3};
    vecs[10] = '{1'b1, 4'b1111, 1'b0, 2'b11, 8, 1, 3};
    vecs[11] = '{1'b1, 4'b1111, 1'b0, 2'b11, 8, 1, 3};
    vecs[12] = '{1'b1, 4'b1111, 1'b0, 2'b11, 8, 1, 3};
    vecs[13] = '{1'b0, 4'b1111, 1'b0, 2'b10, 8, 1, 3};
    vecs[14] = '{1'b0, 4'b1001, 1'b1, 2'b10, 10, 1, 3};
    vecs[15] = '{1'b0, 4'b0000, 1'b1, 2'b10, 10, 1, 3};
    vecs[16] = '{1'b0, 4'b0110, 1'b1, 2'b10, 12, 1, 3};

    rst       = 1'b1;
    vs_in     = 1'b1;
    start_in  = 1'b0;
    pause_in  = 1'b0;
    hit_in    = 4'b0000;
    x_step_sw = 4'd2;
    y_step_sw = 4'd15;
    cyc();
    cyc();
    chk_reset_vals("rst");
    rst = 1'b0;
    cyc();
    chk("idle_hold", 32'(state_out), 32'd0);

    // Tick in IDLE does nothing.
    do_tick(1'b0, 4'b0000, stb);
    chk("idle_tick_stb", 32'(stb), 32'd0);
    chk("idle_tick_state", 32'(state_out), 32'd0);

    pulse_start();
    chk("start_state", 32'(state_out), 32'd1);
    chk("start_x", 32'(x_step_out), 32'd2);
    chk("start_y", 32'(y_step_out), 32'd15);

    foreach (vecs[i]) begin
      do_tick(vecs[i].pause, vecs[i].hit, stb);
      chk($sformatf("v%0d_stb", i), 32'(stb), 32'(vecs[i].stb));
      chk($sformatf("v%0d_state", i), 32'(state_out), 32'(vecs[i].st));
      chk($sformatf("v%0d_bounce", i), 32'(bounce_cnt), 32'(vecs[i].bounce));
      chk($sformatf("v%0d_level", i), 32'(level), FEAT ? 32'(vecs[i].lvl_on) : 32'd0);
      chk($sformatf("v%0d_x", i), 32'(x_step_out), FEAT ? 32'(vecs[i].x_on) : 32'd2);
      chk($sformatf("v%0d_y", i), 32'(y_step_out), 32'd15);
    end

    // Start edge coinciding with a PLAY tick.
    start_in = 1'b1;
    vs_in    = 1'b0;
    hit_in   = 4'b1111;
    pause_in = 1'b0;
    cyc();
    chk("sp_stb", 32'(upd_stb), 32'd0);
    chk("sp_state", 32'(state_out), 32'd1);
    chk("sp_bounce", 32'(bounce_cnt), 32'd0);
    chk("sp_level", 32'(level), 32'd0);
    vs_in    = 1'b1;
    start_in = 1'b0;
    cyc();
    cyc();
    chk("sp_x", 32'(x_step_out), 32'd2);
    for (int i = 0; i < 3; i++) begin
      do_tick(1'b0, 4'b0000, stb);
      chk("sp_serve_stb", 32'(stb), 32'd0);
    end
    chk("sp_play", 32'(state_out), 32'd2);
    do_tick(1'b0, 4'b0001, stb);
    chk("sp_first_stb", 32'(stb), 32'd1);
    chk("sp_bounce1", 32'(bounce_cnt), 32'd1);

    // Restart with x switch 0 (base 1), then saturate bounces and level.
    x_step_sw = 4'd0;
    y_step_sw = 4'd15;
    pulse_start();
    chk("z_x", 32'(x_step_out), 32'd1);
    chk("z_y", 32'(y_step_out), 32'd15);
    chk("z_bounce", 32'(bounce_cnt), 32'd0);
    for (int i = 0; i < 3; i++) do_tick(1'b0, 4'b0000, stb);
    chk("z_play", 32'(state_out), 32'd2);
    for (int k = 1; k <= 70; k++) begin
      do_tick(1'b0, 4'b1111, stb);
      exp_b = (4 * k > 255) ? 255 : 4 * k;
      exp_l = FEAT ? ((k / 2 > 7) ? 7 : k / 2) : 0;
      exp_x = 1 + exp_l;
      chk("sat_stb", 32'(stb), 32'd1);
      chk("sat_bounce", 32'(bounce_cnt), 32'(exp_b));
      chk("sat_level", 32'(level), 32'(exp_l));
      chk("sat_x", 32'(x_step_out), 32'(exp_x));
      chk("sat_y", 32'(y_step_out), 32'd15);
    end

    // Reset in the middle of PLAY.
    rst = 1'b1;
    cyc();
    chk_reset_vals("midrst");
    rst = 1'b0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
